// File: rtl/bcd_display_ctrl.sv
// Iterative double-dabble binary-to-BCD converter with seven-segment decode; BCD_LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: result valid WIDTH+1 cycles after the acceptance edge; one conversion per WIDTH+2 cycles.
// Backpressure: in_ready is high only in IDLE; requests arriving while converting wait in the requester.
module bcd_display_ctrl #(
    parameter int WIDTH = 6,
    parameter int NDIG  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*NDIG-1:0]     bcd,
    output logic [7*NDIG-1:0]     seg,
    output logic                  out_valid,
    output logic                  overflow,
    output logic                  busy
);
    localparam int SW    = 4*NDIG + 4;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int POW10 = (NDIG == 1) ? 10 : (NDIG == 2) ? 100 : (NDIG == 3) ? 1000 : 10000;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0]   val_q, val_d;
    logic [SW-1:0]      scr_q, scr_d, scr_adj;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [4*NDIG-1:0]  bcd_q, bcd_d;
    logic [7*NDIG-1:0]  seg_q, seg_d;
    logic               out_valid_q, out_valid_d;
    logic               overflow_q, overflow_d;
    logic               accept;
    logic               ovf_now;
    logic [3:0]         dig;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic               lead;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q == SHIFT);
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        scr_adj = scr_q;
        for (int n = 0; n < NDIG + 1; n++) begin
            if (scr_q[4*n +: 4] >= 4'd5) scr_adj[4*n +: 4] = scr_q[4*n +: 4] + 4'd3;
        end

        sh_d        = sh_q;
        val_d       = val_q;
        scr_d       = scr_q;
        cnt_d       = cnt_q;
        bcd_d       = bcd_q;
        seg_d       = seg_q;
        out_valid_d = out_valid_q;
        overflow_d  = overflow_q;
        dig         = 4'd0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        lead        = 1'b1;
`endif
        // The guard nibble alone misses overflow when the scratch is narrower than the input range.
        ovf_now = (scr_q[SW-1 -: 4] != 4'd0) || (32'(val_q) >= POW10);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d        = in_data;
                    val_d       = in_data;
                    scr_d       = '0;
                    cnt_d       = CW'(WIDTH);
                    out_valid_d = 1'b0;
                end
            end
            SHIFT: begin
                {scr_d, sh_d} = {scr_adj, sh_q} << 1;
                cnt_d         = cnt_q - CW'(1);
            end
            DONE: begin
                out_valid_d = 1'b1;
                overflow_d  = ovf_now;
                if (ovf_now) begin
                    bcd_d = '1;
                    seg_d = {NDIG{7'b1111110}};
                end else begin
                    bcd_d = scr_q[4*NDIG-1:0];
                    for (int k = NDIG - 1; k >= 0; k--) begin
                        dig              = scr_q[4*k +: 4];
                        seg_d[7*k +: 7]  = seg7(dig);
`ifdef BCD_LEADING_ZERO_BLANK_EN
                        if (k != 0 && lead && dig == 4'd0) seg_d[7*k +: 7] = 7'b1111111;
                        else lead = 1'b0;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q        <= '0;
            val_q       <= '0;
            scr_q       <= '0;
            cnt_q       <= '0;
            bcd_q       <= '0;
            seg_q       <= '1;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            val_q       <= val_d;
            scr_q       <= scr_d;
            cnt_q       <= cnt_d;
            bcd_q       <= bcd_d;
            seg_q       <= seg_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bcd       = bcd_q;
    assign seg       = seg_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: a WIDTH=6 instance for the main path and a WIDTH=7 instance for overflow.
module tb_bcd_display_ctrl;
    logic        clk;
    logic        rst;

    logic [5:0]  d6;
    logic        v6;
    logic        r6;
    logic [7:0]  b6;
    logic [13:0] s6;
    logic        ov6_valid;
    logic        ovf6;
    logic        busy6;

    logic [6:0]  d7;
    logic        v7;
    logic        r7;
    logic [7:0]  b7;
    logic [13:0] s7;
    logic        ov7_valid;
    logic        ovf7;
    logic        busy7;

    int checks = 0;
    int errors = 0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'b1111111;
`else
    localparam logic [6:0] LZ = 7'b0000001;
`endif

    bcd_display_ctrl #(.WIDTH(6), .NDIG(2)) dut6 (
        .clk(clk), .rst(rst), .in_data(d6), .in_valid(v6), .in_ready(r6),
        .bcd(b6), .seg(s6), .out_valid(ov6_valid), .overflow(ovf6), .busy(busy6)
    );

    bcd_display_ctrl #(.WIDTH(7), .NDIG(2)) dut7 (
        .clk(clk), .rst(rst), .in_data(d7), .in_valid(v7), .in_ready(r7),
        .bcd(b7), .seg(s7), .out_valid(ov7_valid), .overflow(ovf7), .busy(busy7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus only: launch a request from IDLE and count edges until out_valid, bounded.
    task automatic run6(input logic [5:0] v, output int lat);
        v6 = 1'b1;
        d6 = v;
        @(posedge clk); #1;
        v6 = 1'b0;
        lat = 0;
        while (!ov6_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run7(input logic [6:0] v, output int lat);
        v7 = 1'b1;
        d7 = v;
        @(posedge clk); #1;
        v7 = 1'b0;
        lat = 0;
        while (!ov7_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (ov6_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov6_valid); end
        checks++; if (r6 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", r6); end
        checks++; if (s6 !== 14'h3FFF) begin errors++; $display("FAIL reset_seg got %h want 3fff", s6); end
        checks++; if ({b6, ovf6, busy6} !== 10'd0) begin errors++; $display("FAIL reset_bcd_ovf_busy got %h want 0", {b6, ovf6, busy6}); end
        checks++; if ({s7, ov7_valid} !== 15'h7FFE) begin errors++; $display("FAIL reset_dut7 got %h want 7ffe", {s7, ov7_valid}); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        run6(6'd45, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL basic_latency got %0d want 7", lat); end
        checks++; if (b6 !== 8'h45) begin errors++; $display("FAIL basic_bcd got %h want 45", b6); end
        checks++; if (s6 !== {7'b1001100, 7'b0100100}) begin errors++; $display("FAIL basic_seg got %b want 10011000100100", s6); end
        checks++; if ({ovf6, busy6, r6} !== 3'b001) begin errors++; $display("FAIL basic_flags got %b want 001", {ovf6, busy6, r6}); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if ({ov6_valid, b6} !== {1'b1, 8'h45}) begin errors++; $display("FAIL basic_hold got %h want 145", {ov6_valid, b6}); end
    endtask

    task automatic test_boundary();
        int lat;
        logic [5:0]  v;
        logic [7:0]  eb;
        logic [13:0] es;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0:       begin v = 6'd0;  eb = 8'h00; es = {LZ, 7'b0000001}; end
                1:       begin v = 6'd9;  eb = 8'h09; es = {LZ, 7'b0000100}; end
                2:       begin v = 6'd10; eb = 8'h10; es = {7'b1001111, 7'b0000001}; end
                default: begin v = 6'd63; eb = 8'h63; es = {7'b0100000, 7'b0000110}; end
            endcase
            run6(v, lat);
            checks++; if ({b6, ovf6} !== {eb, 1'b0} || lat !== 7) begin errors++; $display("FAIL boundary_bcd in=%0d got %h/%0d want %h/7", v, b6, lat, eb); end
            checks++; if (s6 !== es) begin errors++; $display("FAIL boundary_seg in=%0d got %b want %b", v, s6, es); end
        end
    endtask

    task automatic test_overflow();
        int lat;
        run7(7'd100, lat);
        checks++; if (lat !== 8) begin errors++; $display("FAIL ovf_latency got %0d want 8", lat); end
        checks++; if ({ovf7, b7} !== {1'b1, 8'hFF}) begin errors++; $display("FAIL ovf100_bcd got %h want 1ff", {ovf7, b7}); end
        checks++; if (s7 !== {7'b1111110, 7'b1111110}) begin errors++; $display("FAIL ovf100_seg got %b want 11111101111110", s7); end
        run7(7'd99, lat);
        checks++; if ({ovf7, b7} !== {1'b0, 8'h99}) begin errors++; $display("FAIL ovf99_bcd got %h want 099", {ovf7, b7}); end
        checks++; if (s7 !== {7'b0000100, 7'b0000100}) begin errors++; $display("FAIL ovf99_seg got %b want 00001000000100", s7); end
        run7(7'd127, lat);
        checks++; if ({ovf7, b7, s7} !== {1'b1, 8'hFF, 7'b1111110, 7'b1111110}) begin errors++; $display("FAIL ovf127 got %h want %h", {ovf7, b7, s7}, {1'b1, 8'hFF, 7'b1111110, 7'b1111110}); end
    endtask

    task automatic test_back_to_back();
        int bad_rdy;
        int lat;
        bad_rdy = 0;
        v6 = 1'b1;
        d6 = 6'd20;
        @(posedge clk); #1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) d6 = 6'd33;
            if (r6 !== 1'b0 || ov6_valid !== 1'b0) bad_rdy++;
        end
        checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL b2b_ready_low got %0d bad cycles want 0", bad_rdy); end
        @(posedge clk); #1;
        checks++; if ({ov6_valid, r6, b6} !== {2'b11, 8'h20}) begin errors++; $display("FAIL b2b_first got %h want 320", {ov6_valid, r6, b6}); end
        @(posedge clk); #1;
        v6 = 1'b0;
        checks++; if ({ov6_valid, busy6} !== 2'b01) begin errors++; $display("FAIL b2b_second_accept got %b want 01", {ov6_valid, busy6}); end
        lat = 0;
        while (!ov6_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 7 || b6 !== 8'h33) begin errors++; $display("FAIL b2b_second got %h/%0d want 33/7", b6, lat); end
    endtask

    task automatic test_abort();
        int seen;
        v6 = 1'b1;
        d6 = 6'd50;
        @(posedge clk); #1;
        v6 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if ({ov6_valid, busy6, r6, b6, s6} !== {3'b001, 8'h00, 14'h3FFF}) begin errors++; $display("FAIL abort_reset got %h want %h", {ov6_valid, busy6, r6, b6, s6}, {3'b001, 8'h00, 14'h3FFF}); end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov6_valid !== 1'b0 || busy6 !== 1'b0) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_result got %0d bad cycles want 0", seen); end
    endtask

    task automatic test_blank();
        int lat;
        run6(6'd7, lat);
        checks++; if (b6 !== 8'h07) begin errors++; $display("FAIL blank_bcd got %h want 07", b6); end
        checks++; if (s6[6:0] !== 7'b0001111) begin errors++; $display("FAIL blank_low_seg got %b want 0001111", s6[6:0]); end
        checks++; if (s6[13:7] !== LZ) begin errors++; $display("FAIL blank_high_seg got %b want %b", s6[13:7], LZ); end
    endtask

    initial begin
        v6 = 1'b0; d6 = '0;
        v7 = 1'b0; d7 = '0;
        test_reset();
        test_basic();
        test_boundary();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_blank();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
- Sequential binary-to-BCD conversion controller for the switch-driven seven-segment display path.
- Accepts a binary value over a valid/ready handshake and runs an iterative shift-and-add-3 (double-dabble) conversion, one bit per clock.
- Holds NDIG BCD digits plus active-low seven-segment codes for HEX0..HEX(NDIG-1).
- Replaces the chained compare/subtract logic currently used for multi-digit display.

Parameters:
- WIDTH, 6: binary input width, legal range 1..10.
- NDIG, 2: number of BCD digits / displays driven, legal range 1..4.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  unsigned binary value to convert.
- in_valid  input  1  request to convert in_data.
- in_ready  output  1  high when a request can be accepted.
- bcd  output  4*NDIG  converted digits; digit k is at bits [4k+3:4k], digit 0 is least significant.
- seg  output  7*NDIG  segment codes; display k is at bits [7k+6:7k], order a..g from MSB to LSB, active-low.
- out_valid  output  1  bcd/seg hold a completed conversion.
- overflow  output  1  last accepted value exceeded 10^NDIG-1.
- busy  output  1  conversion in progress.

Behaviour:
- Reset (async, rst=1): state IDLE; in_ready=1; out_valid=0; overflow=0; busy=0; bcd all 0; seg all 7'b1111111 (blank).
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the shift register, clear the BCD scratch, load bit counter = WIDTH, go to SHIFT.
  - out_valid drops to 0 on the acceptance edge.
- SHIFT:
  - in_ready=0, busy=1.
  - Each cycle: every scratch nibble >=5 gets +3 first, then {scratch,shift} shifts left by 1 and the counter decrements.
  - When the counter reaches 1 on a shift cycle, go to DONE next.
  - Exactly WIDTH SHIFT cycles.
- DONE (one cycle):
  - Register bcd from the scratch and seg from the per-digit decode.
  - Set out_valid=1 and overflow; busy=0. Return to IDLE.
- Latency: acceptance edge at cycle 0 -> out_valid high after the edge of cycle WIDTH+1. Throughput is one conversion per WIDTH+2 cycles.
- Output hold: out_valid, bcd, seg and overflow hold until the next acceptance or reset. They are not cleared by in_valid deassertion.
- Scratch width: 4*NDIG+4 bits (one guard nibble) so that overflow is detectable.
- Overflow:
  - overflow=1 if the guard nibble is nonzero or the value is >=10^NDIG.
  - When overflow=1, bcd is all 4'hF and every seg shows "-" (7'b1111110).
- Decode (0..9): 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100. Any other nibble decodes to 1111111.
- in_valid during SHIFT/DONE is ignored (in_ready=0). The requester must hold in_valid until accepted.
- in_data changes after acceptance do not affect the conversion in flight.
- Reset mid-SHIFT aborts immediately to the reset values; no partial result is exposed.
- Value 0 converts to all-zero digits; seg shows "0" on every display unless the optional feature is enabled.

Optional Feature:
- Macro: BCD_LEADING_ZERO_BLANK_EN.
- Defined:
  - In DONE, any digit above digit 0 that is zero and has only zero digits above it gets seg=1111111.
  - bcd is unchanged.
  - Digit 0 is never blanked.
  - Overflow display ("-") takes priority over blanking.
- Undefined: all digits are decoded normally, so leading zeros are displayed.

Test Plan:
- Reset then idle:
  - rst pulse mid-cycle -> out_valid=0, in_ready=1, seg=14'h3FFF immediately (async).
- Basic conversion:
  - WIDTH=6, NDIG=2, in_data=45 accepted at cycle 0 -> out_valid rises after cycle 7 edge.
  - Result bcd=8'h45, seg={1001100,0100100}, overflow=0.
- Boundary values:
  - in_data=0 -> bcd=8'h00.
  - in_data=9 -> bcd=8'h09.
  - in_data=10 -> bcd=8'h10.
  - in_data=63 -> bcd=8'h63.
- Overflow:
  - WIDTH=7, NDIG=2, in_data=100 -> overflow=1, bcd=8'hFF, seg both 1111110.
  - in_data=99 -> overflow=0, bcd=8'h99.
- Handshake / abort:
  - in_valid held high with in_data changed at cycle 2 -> in_ready=0 for cycles 1..7 and the result equals the originally latched value.
  - Second request accepted on the first IDLE cycle.
  - rst at cycle 3 -> out_valid stays 0.
- Optional feature:
  - With BCD_LEADING_ZERO_BLANK_EN defined, in_data=7 -> seg[13:7]=1111111, seg[6:0]=0001111, bcd=8'h07.
  - Without it, seg[13:7]=0000001.
